// File: rtl/nes_pkg.sv
// Shared types and constants for the NES pad link blocks.
package nes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } txState_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic [3:0] BIT_NONE   = 4'b1111;
  localparam int         FRAME_BITS = 8;

endpackage

// File: rtl/nes_edge_sync.sv
// Brings an asynchronous pin into the clk domain through a flop chain and
// reports the synchronized level plus one-cycle rise and fall strobes.
module nes_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prevLevel;

  // Synchronizer chain followed by a one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain     <= '0;
      prevLevel <= 1'b0;
    end else begin
      chain     <= {chain[SYNC_STAGES-2:0], din};
      prevLevel <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prevLevel;
  assign fall  = ~level & prevLevel;

endmodule

// File: rtl/nes_controller_tx.sv
// Controller-side NES pad emulator: captures buttons while latch is high and
// shifts them out active-low, one bit per console pulse rise.
// Optional turbo on A/B is compiled in with NES_TX_TURBO_EN.
import nes_pkg::*;

module nes_controller_tx #(
  parameter int SYNC_STAGES   = 2,
  parameter int TURBO_LATCHES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       latch,
  input  logic       pulse,
  input  logic [7:0] buttons,
  output logic       data,
  output logic [3:0] bitIndex,
  output logic       frameDone
);

  txState_t   state;
  logic [7:0] shreg;
  logic [3:0] count;
  logic [7:0] loadVal;

  logic latchLevel, latchRise, latchFall;
  logic pulseLevel, pulseRise, pulseFall;

  nes_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) latchSync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (latch),
    .level   (latchLevel),
    .rise    (latchRise),
    .fall    (latchFall)
  );

  nes_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) pulseSync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (pulse),
    .level   (pulseLevel),
    .rise    (pulseRise),
    .fall    (pulseFall)
  );

`ifdef NES_TX_TURBO_EN
  localparam logic [7:0] TURBO_MASK = 8'(1 << BTN_A) | 8'(1 << BTN_B);

  logic       turboPhase;
  logic [7:0] turboCnt;

  // Flip the turbo phase once every TURBO_LATCHES latch rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      turboPhase <= 1'b0;
      turboCnt   <= 8'd0;
    end else if (latchRise) begin
      if (turboCnt == 8'(TURBO_LATCHES)) begin
        turboCnt   <= 8'd1;
        turboPhase <= ~turboPhase;
      end else begin
        turboCnt <= turboCnt + 8'd1;
      end
    end
  end

  assign loadVal = turboPhase ? (~buttons | TURBO_MASK) : ~buttons;
`else
  assign loadVal = ~buttons;
`endif

  // Frame sequencer; synced latch high overrides every state and restarts the load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shreg     <= 8'hFF;
      count     <= 4'd0;
      data      <= 1'b1;
      bitIndex  <= BIT_NONE;
      frameDone <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      if (latchLevel) begin
        state    <= LOAD;
        shreg    <= loadVal;
        count    <= 4'd0;
        data     <= loadVal[0];
        bitIndex <= 4'd1;
      end else begin
        case (state)
          IDLE: begin
            data     <= 1'b1;
            bitIndex <= BIT_NONE;
          end
          LOAD: begin
            shreg    <= loadVal;
            data     <= loadVal[0];
            bitIndex <= 4'd1;
            if (latchFall) begin
              state <= SHIFT;
              count <= 4'd1;
            end
          end
          SHIFT: begin
            if (pulseRise) begin
              if (count == 4'(FRAME_BITS)) begin
                state     <= DONE;
                frameDone <= 1'b1;
                data      <= 1'b1;
                bitIndex  <= BIT_NONE;
              end else begin
                shreg    <= {1'b1, shreg[7:1]};
                data     <= shreg[1];
                count    <= count + 4'd1;
                bitIndex <= count + 4'd1;
              end
            end
          end
          default: begin
            data     <= 1'b1;
            bitIndex <= BIT_NONE;
          end
        endcase
      end
    end
  end

endmodule
